maxnet_loader: RTL and testbench

//  Front end and write side of the MaxNet winner-take-all datapath.
//  - Accepts N input scores over a valid/ready stream and writes them into the X memory.
//  - Writes the N x N lateral-inhibition weight matrix into the W memory.
//  - Pulses start to the MaxNet core, waits for done, and returns the one-hot winner on a result handshake.

---
 rtl/maxnet_pkg.sv | 32 +++
 rtl/maxnet_weight_gen.sv | 35 +++
 rtl/maxnet_loader.sv | 162 ++++++++++++++++
 tb/tb_maxnet_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// MaxNet loader shared constants, state enum and weight helper.
// Optional watchdog build macro: MAXNET_TIMEOUT_EN.
package maxnet_pkg;

    localparam int DATA_W = 5;
    localparam int N      = 4;
    localparam int FRAC_W = 3;
    localparam int AW     = $clog2(N);
    localparam int CW     = $clog2(N * N);

    localparam logic [DATA_W-1:0] EPS_CODE = 5'b11111;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_GEN_W,
        ST_START,
        ST_WAIT,
        ST_RESULT
    } ld_state_t;

    // Self weight is +1.0, every lateral weight is -epsilon.
    function automatic logic [DATA_W-1:0] w_value(
        input logic [AW-1:0] row,
        input logic [AW-1:0] col
    );
        logic [DATA_W-1:0] diag;
        diag         = '0;
        diag[FRAC_W] = 1'b1;
        return (row == col) ? diag : EPS_CODE;
    endfunction

endpackage

// File: rtl/maxnet_weight_gen.sv
// Row-major sweep of the N x N lateral-inhibition matrix.
// Writes one weight per cycle while go is held; last flags the final write.
module maxnet_weight_gen
    import maxnet_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic              w_wr_en,
    output logic [AW-1:0]     row,
    output logic [AW-1:0]     col,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    logic [CW-1:0] cnt;

    // Sweep counter: advances while go, parked at zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (go) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    assign w_wr_en = go;
    assign row     = cnt[CW-1:AW];
    assign col     = cnt[AW-1:0];
    assign data    = w_value(row, col);
    assign last    = go && (cnt == CW'(N * N - 1));

endmodule

// File: rtl/maxnet_loader.sv
// MaxNet front end: loads scores into X, weights into W, runs the core.
// Define MAXNET_TIMEOUT_EN to add the WAIT-state watchdog and res_err.
module maxnet_loader
    import maxnet_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              x_wr_en,
    output logic [AW-1:0]     x_wr_addr,
    output logic [DATA_W-1:0] x_wr_data,
    output logic              w_wr_en,
    output logic [AW-1:0]     w_wr_row,
    output logic [AW-1:0]     w_wr_col,
    output logic [DATA_W-1:0] w_wr_data,
    output logic              mn_start,
    input  logic              mn_done,
    input  logic [N:0]        mn_max,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N:0]        res_max,
    output logic              res_err,
    output logic              busy
);

    ld_state_t     state;
    ld_state_t     nxt;
    logic [AW-1:0] beat;
    logic          accept;
    logic          wg_go;
    logic          wg_last;
    logic          done_seen;
    logic          wd_exp;

    assign in_ready  = (state == ST_LOAD);
    assign busy      = (state != ST_LOAD);
    assign mn_start  = (state == ST_START);
    assign res_valid = (state == ST_RESULT);
    assign accept    = in_valid && in_ready;
    assign x_wr_en   = accept;
    assign x_wr_addr = beat;
    assign x_wr_data = in_data;
    assign wg_go     = (state == ST_GEN_W);
    assign done_seen = (state == ST_WAIT) && mn_done;

    maxnet_weight_gen u_wgen (
        .clk     (clk),
        .rst     (rst),
        .go      (wg_go),
        .w_wr_en (w_wr_en),
        .row     (w_wr_row),
        .col     (w_wr_col),
        .data    (w_wr_data),
        .last    (wg_last)
    );

`ifdef MAXNET_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 64;
    localparam int TW          = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] wd_cnt;
    logic          err_q;

    // Watchdog: counts cycles spent in WAIT, cleared elsewhere.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    // A done in the expiry cycle still wins over the timeout.
    assign wd_exp = (state == ST_WAIT) && !mn_done
                  && (wd_cnt == TW'(TIMEOUT_CYC - 1));

    // Error flag: set on expiry, dropped once the result is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (done_seen) begin
            err_q <= 1'b0;
        end else if (wd_exp) begin
            err_q <= 1'b1;
        end else if (res_valid && res_ready) begin
            err_q <= 1'b0;
        end
    end

    assign res_err = err_q;
`else
    assign wd_exp  = 1'b0;
    assign res_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LOAD;
        end else begin
            state <= nxt;
        end
    end

    // Beat counter: one step per accepted score, wraps after N-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat <= '0;
        end else if (accept) begin
            beat <= beat + 1'b1;
        end
    end

    // Winner register: captured only from a done seen in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_max <= '0;
        end else if (done_seen) begin
            res_max <= mn_max;
        end else if (wd_exp) begin
            res_max <= '0;
        end
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        unique case (state)
            ST_LOAD: begin
                if (accept && (beat == AW'(N - 1))) begin
                    nxt = ST_GEN_W;
                end
            end
            ST_GEN_W: begin
                if (wg_last) begin
                    nxt = ST_START;
                end
            end
            ST_START: begin
                nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mn_done || wd_exp) begin
                    nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    nxt = ST_LOAD;
                end
            end
            default: begin
                nxt = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_maxnet_loader.sv
// Randomized self-checking bench for maxnet_loader.
// Build with MAXNET_TIMEOUT_EN to exercise the watchdog path.
module tb_maxnet_loader;
    import maxnet_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              x_wr_en;
    logic [AW-1:0]     x_wr_addr;
    logic [DATA_W-1:0] x_wr_data;
    logic              w_wr_en;
    logic [AW-1:0]     w_wr_row;
    logic [AW-1:0]     w_wr_col;
    logic [DATA_W-1:0] w_wr_data;
    logic              mn_start;
    logic              mn_done;
    logic [N:0]        mn_max;
    logic              res_valid;
    logic              res_ready;
    logic [N:0]        res_max;
    logic              res_err;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int xaddr[$];
    int xdata[$];
    int wrow[$];
    int wcol[$];
    int wdat[$];
    int wcyc[$];

    maxnet_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .x_wr_en   (x_wr_en),
        .x_wr_addr (x_wr_addr),
        .x_wr_data (x_wr_data),
        .w_wr_en   (w_wr_en),
        .w_wr_row  (w_wr_row),
        .w_wr_col  (w_wr_col),
        .w_wr_data (w_wr_data),
        .mn_start  (mn_start),
        .mn_done   (mn_done),
        .mn_max    (mn_max),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_max   (res_max),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Memory-write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            if (x_wr_en) begin
                xaddr.push_back(int'(x_wr_addr));
                xdata.push_back(int'(x_wr_data));
            end
            if (w_wr_en) begin
                wrow.push_back(int'(w_wr_row));
                wcol.push_back(int'(w_wr_col));
                wdat.push_back(int'(w_wr_data));
                wcyc.push_back(cyc);
            end
        end
    end

    task automatic clear_mon();
        xaddr.delete(); xdata.delete();
        wrow.delete(); wcol.delete(); wdat.delete(); wcyc.delete();
    endtask

    // gap_mode: 0 back-to-back, 1 alternating idle, 2 random idles.
    task automatic load_beats(input logic [DATA_W-1:0] sc [N],
                              input int gap_mode);
        for (int k = 0; k < N; k++) begin
            int g;
            g = 0;
            if (gap_mode == 1 && k > 0) g = 1;
            if (gap_mode == 2) g = $urandom_range(0, 2);
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = DATA_W'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = sc[k];
            @(posedge clk); #1;
        end
    endtask

    // Full frame against the reference: X contents, W matrix, timing, result.
    task automatic run_frame(input logic [DATA_W-1:0] sc [N],
                             input int gap_mode, input int dly,
                             input int rdy_dly);
        logic [N:0] mx;
        int         lat;
        int         exp_w;
        bit         found;
        mx = '0;
        mx[$urandom_range(0, N)] = 1'b1;
        clear_mon();
        load_beats(sc, gap_mode);
        in_valid = 1'b1;
        in_data  = DATA_W'($urandom);
        found = 0;
        lat   = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 3) begin
                check("bp_in_ready", in_ready, 0);
                check("bp_no_xwr", x_wr_en, 0);
            end
            if (mn_start) begin
                lat   = k + 1;
                found = 1;
                break;
            end
        end
        check("start_seen", found, 1);
        check("start_lat", lat, N * N + 1);
        in_valid = 1'b0;
        check("x_cnt", xaddr.size(), N);
        for (int i = 0; i < N && i < xaddr.size(); i++) begin
            check("x_addr", xaddr[i], i);
            check("x_data", xdata[i], int'(sc[i]));
        end
        check("w_cnt", wrow.size(), N * N);
        for (int i = 0; i < N * N && i < wrow.size(); i++) begin
            exp_w = (i / N == i % N) ? (1 << FRAC_W) : 31;
            check("w_row", wrow[i], i / N);
            check("w_col", wcol[i], i % N);
            check("w_data", wdat[i], exp_w);
        end
        if (wcyc.size() == N * N)
            check("w_consec", wcyc[N*N-1] - wcyc[0], N * N - 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("start_1cyc", mn_start, 0);
        check("wait_busy", busy, 1);
        repeat (dly) begin
            mn_max = (N+1)'($urandom);
            @(posedge clk); #1;
        end
        mn_done = 1'b1;
        mn_max  = mx;
        @(posedge clk); #1;
        mn_done = 1'b0;
        mn_max  = (N+1)'($urandom);
        for (int r = 0; r < rdy_dly; r++) begin
            @(negedge clk);
            check("res_valid_hold", res_valid, 1);
            check("res_max_hold", res_max, mx);
            check("hold_no_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("res_valid_xfer", res_valid, 1);
        check("res_max_xfer", res_max, mx);
        check("res_err_ok", res_err, 0);
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("post_in_ready", in_ready, 1);
        check("post_res_valid", res_valid, 0);
        check("post_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_scores(output logic [DATA_W-1:0] sc [N]);
        for (int i = 0; i < N; i++) sc[i] = DATA_W'($urandom);
    endtask

    initial begin
        logic [DATA_W-1:0] sc [N];
        bit                hold_ok;
        int                k;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mn_done   = 1'b0;
        mn_max    = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_xwr", x_wr_en, 0);
        check("rst_wwr", w_wr_en, 0);
        check("rst_start", mn_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_max", res_max, 0);
        check("rst_res_err", res_err, 0);
        @(posedge clk); #1;

        // Directed load 3,7,1,5 back-to-back.
        sc[0] = 5'd3; sc[1] = 5'd7; sc[2] = 5'd1; sc[3] = 5'd5;
        run_frame(sc, 0, 2, 5);

        // Gapped load with in_valid toggling.
        rand_scores(sc);
        run_frame(sc, 1, 0, 0);

        // Spurious done while loading.
        mn_done = 1'b1;
        mn_max  = 5'b00100;
        @(posedge clk); #1;
        mn_done = 1'b0;
        @(negedge clk);
        check("spur_busy", busy, 0);
        check("spur_res_valid", res_valid, 0);
        check("spur_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Reset in the middle of the weight sweep.
        rand_scores(sc);
        load_beats(sc, 0);
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_wwr", w_wr_en, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset after a partial load; next frame must restart at X[0].
        in_valid = 1'b1;
        in_data  = 5'd9;
        repeat (2) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rand_scores(sc);
        run_frame(sc, 0, 1, 1);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            rand_scores(sc);
            run_frame(sc, 2, $urandom_range(0, 20), $urandom_range(0, 6));
        end

        // Core that never answers.
        rand_scores(sc);
        clear_mon();
        load_beats(sc, 0);
        in_valid = 1'b0;
        k = 0;
        while (!mn_start && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("wd_start_seen", mn_start, 1);
`ifdef MAXNET_TIMEOUT_EN
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (res_valid) break;
            k++;
        end
        check("wd_cycles", k, 64);
        check("wd_res_valid", res_valid, 1);
        check("wd_res_err", res_err, 1);
        check("wd_res_max", res_max, 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("wd_err_clr", res_err, 0);
        check("wd_post_valid", res_valid, 0);
`else
        hold_ok = 1;
        repeat (1000) begin
            @(negedge clk);
            if (!busy || res_valid || res_err) hold_ok = 0;
        end
        check("wait_forever", hold_ok, 1);
        @(posedge clk); #1;
        mn_done = 1'b1;
        mn_max  = 5'b10000;
        @(posedge clk); #1;
        mn_done   = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("late_res_max", res_max, 5'b10000);
        check("late_res_valid", res_valid, 1);
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("late_in_ready", in_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
